// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg: shared MDU types (divider FSM states, operation codes, width). Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } nrdiv_state_e;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MFHI  = 3'd5,
    MDU_MFLO  = 3'd6
  } mdu_op_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nrdiv_step.sv
// ============================================================================
// nrdiv_step: one combinational non-restoring add/sub iteration. Rev 1.0
// ============================================================================
`default_nettype none

module nrdiv_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quot_o
);

  logic [W:0] rem_sh;

  // The remainder stays within [-div, div), so 33-bit wrap-around is harmless.
  always_comb begin
    rem_sh = {rem_i[W-1:0], quot_i[W-1]};
    if (rem_i[W]) begin
      rem_o = rem_sh + {1'b0, div_i};
    end else begin
      rem_o = rem_sh - {1'b0, div_i};
    end
    quot_o = {quot_i[W-2:0], ~rem_o[W]};
  end

endmodule

`default_nettype wire

// File: rtl/nonrestoring_div.sv
// ============================================================================
// nonrestoring_div: multi-cycle signed/unsigned 32-bit non-restoring divider.
// Optional early-out build macro: NRDIV_EARLY_OUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module nonrestoring_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = mdu_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  input  logic                 en,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 claim
);

  localparam int CW = $clog2(WIDTH);

  nrdiv_state_e       state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   amag, bmag;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quot;
  logic [WIDTH-1:0]   rem_mag, fix_rem, fix_quot;

  assign amag = mag(a_q, sign_q);
  assign bmag = mag(b_q, sign_q);

  nrdiv_step #(.W(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .div_i  (div_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  // Final correction and sign application; a zero divisor yields all-ones / dividend.
  always_comb begin
    rem_mag  = rem_q[WIDTH-1:0] + (rem_q[WIDTH] ? div_q : '0);
    fix_quot = (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quot_q : quot_q;
    fix_rem  = (sign_q && a_q[WIDTH-1]) ? -rem_mag : rem_mag;
    if (b_q == '0) begin
      fix_quot = '1;
      fix_rem  = a_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (annul) begin
      state_d = IDLE;
    end else if (en) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            sign_d  = sign;
            state_d = PREP;
          end
        end
        PREP: begin
          div_d   = bmag;
          quot_d  = amag;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ITER;
`ifdef NRDIV_EARLY_OUT_EN
          if ((b_q == '0) || (amag < bmag)) begin
            quot_d  = (b_q == '0) ? '1 : '0;
            rem_d   = {1'b0, amag};
            state_d = FIX;
          end
`endif
        end
        ITER: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        FIX: begin
          result_d = {fix_rem, fix_quot};
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      div_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == DONE);
  assign claim  = (state_q == FIX);

endmodule

`default_nettype wire

// File: tb/tb_nonrestoring_div.sv
// ============================================================================
// tb_nonrestoring_div: directed + random scoreboard bench for nonrestoring_div. Rev 1.0
// ============================================================================
`default_nettype none

module tb_nonrestoring_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        sign;
  logic [31:0] a, b;
  logic        start, en, annul;
  logic [63:0] result;
  logic        ready, claim;

  int passed = 0;
  int total  = 0;
  logic [63:0] sb[$];

`ifdef NRDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  nonrestoring_div #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .sign   (sign),
    .a      (a),
    .b      (b),
    .start  (start),
    .en     (en),
    .annul  (annul),
    .result (result),
    .ready  (ready),
    .claim  (claim)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference division: truncating, remainder follows the dividend.
  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    int sx, sy, q, r;
    if (y == 32'h0) return {x, 32'hFFFFFFFF};
    if (s) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      sx = x;
      sy = y;
      q  = sx / sy;
      r  = sx % sy;
      return {32'(r), 32'(q)};
    end
    return {x % y, x / y};
  endfunction

  // Cycle of first ready, counting the start-sampling edge as cycle 1.
  function automatic int lat(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my;
    mx = (s && x[31]) ? -x : x;
    my = (s && y[31]) ? -y : y;
    if (EARLY && (y == 32'h0 || mx < my)) return 3;
    return 35;
  endfunction

  task automatic do_div(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int exp_lat,
                        input int pause_at, input int pause_len, input int poke_at);
    int cyc, claim_cnt, claim_cyc;
    logic [63:0] exp_r;
    sb.push_back(exp);
    sign  = s;
    a     = x;
    b     = y;
    start = 1'b1;
    en    = 1'b1;
    tick;
    cyc       = 1;
    start     = 1'b0;
    claim_cnt = 0;
    claim_cyc = 0;
    while (!ready && cyc < 200) begin
      en    = !(cyc >= pause_at && cyc < pause_at + pause_len);
      start = (cyc == poke_at);
      if (start) a = ~a;
      tick;
      cyc++;
      if (claim) begin
        claim_cnt++;
        claim_cyc = cyc;
      end
    end
    en    = 1'b1;
    start = 1'b0;
    exp_r = sb.pop_front();
    check("latency", 64'(cyc), 64'(exp_lat));
    check("claim_cnt", 64'(claim_cnt), 64'd1);
    check("claim_cyc", 64'(claim_cyc), 64'(exp_lat - 1));
    check("result", result, exp_r);
  endtask

  initial begin
    int seen;
    logic        rs;
    logic [31:0] rx, ry;

    rst = 1'b0; sign = 1'b0; a = '0; b = '0; start = 1'b0; en = 1'b1; annul = 1'b0;
    tick;
    tick;
    check("rst_result", result, 64'h0);
    check("rst_ready", {63'h0, ready}, 64'h0);
    check("rst_claim", {63'h0, claim}, 64'h0);
    rst = 1'b1;
    tick;

    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 35, 1000, 0, -1);
    tick; tick; tick;
    check("hold_ready", {63'h0, ready}, 64'h1);
    check("hold_result", result, 64'h00000002_0000000E);

    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 35, 1000, 0, -1);
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 35, 1000, 0, -1);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 35, 1000, 0, -1);
    do_div(1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, lat(1'b0, 32'd5, 32'd0), 1000, 0, -1);
    do_div(1'b0, 32'd3, 32'd10, 64'h00000003_00000000, lat(1'b0, 32'd3, 32'd10), 1000, 0, -1);

    // Freeze for 10 cycles mid-iteration, and a stray start inside the run.
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 45, 10, 10, -1);
    do_div(1'b1, 32'hFFFF0000, 32'd12345, model(1'b1, 32'hFFFF0000, 32'd12345), 35, 1000, 0, 15);

    // Annul during iteration: back to idle, ready must not rise.
    sign = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    annul = 1'b1;
    tick;
    annul = 1'b0;
    check("annul_ready", {63'h0, ready}, 64'h0);
    check("annul_claim", {63'h0, claim}, 64'h0);
    seen = 0;
    repeat (40) begin
      tick;
      if (ready || claim) seen++;
    end
    check("annul_idle", 64'(seen), 64'd0);

    do_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 35, 1000, 0, -1);

    // Asynchronous reset at cycle 20 of an operation.
    sign = 1'b0; a = 32'd77; b = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (19) tick;
    #2 rst = 1'b0;
    #1;
    check("arst_result", result, 64'h0);
    check("arst_ready", {63'h0, ready}, 64'h0);
    tick;
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      tick;
      if (ready || claim || result != 64'h0) seen++;
    end
    check("arst_wait", 64'(seen), 64'd0);
    do_div(1'b0, 32'd77, 32'd5, 64'h00000002_0000000F, 35, 1000, 0, -1);

    for (int i = 0; i < 4; i++) begin
      rs = i[0];
      rx = $urandom;
      ry = 32'($urandom_range(1, 5000));
      if (rs && i[1]) ry = -ry;
      do_div(rs, rx, ry, model(rs, rx, ry), lat(rs, rx, ry), 1000, 0, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nonrestoring_div.md
NONRESTORING_DIV -- requirements
Module: nonrestoring_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sign  input  1  1 = signed division, 0 = unsigned; sampled with start.
REQ-005 SHALL have port a  input  32  dividend; sampled with start.
REQ-006 SHALL have port b  input  32  divisor; sampled with start.
REQ-007 SHALL have port start  input  1  request a new division.
REQ-008 SHALL have port en  input  1  advance enable; 0 freezes all state.
REQ-009 SHALL have port annul  input  1  abort the current operation.
REQ-010 SHALL have port result  output  64  {remainder[63:32], quotient[31:0]}, HI/LO layout.
REQ-011 SHALL have port ready  output  1  result valid.
REQ-012 SHALL have port claim  output  1  ready rises next enabled cycle.

Function
REQ-013 SHALL implement the FSM states IDLE, PREP, ITER, FIX and DONE.
REQ-014 In IDLE with start=1 and en=1, SHALL latch a, b and sign, then go to PREP.
REQ-015 PREP SHALL form |a| and |b| (magnitudes when sign=1), clear the 33-bit partial remainder, load counter=31, and go to ITER.
REQ-016 Each ITER cycle SHALL perform one non-restoring step: shift {rem,quot} left; subtract |b| if rem>=0, else add it; quotient bit = ~rem_sign; decrement the counter; leave for FIX at counter 0.
REQ-017 FIX SHALL add |b| back if rem<0, apply signs (quotient negated if sign(a)^sign(b), remainder takes sign(a)), register result, then go to DONE.
REQ-018 claim SHALL be 1 exactly in FIX; ready SHALL be 1 exactly in DONE.
REQ-019 With en=1 throughout, ready SHALL rise 35 cycles after the start-sampling edge (1 PREP + 32 ITER + 1 FIX + 1).
REQ-020 DONE SHALL hold ready and result stable until start=1 (new operation, go to PREP) or annul=1 (go to IDLE).
REQ-021 en=0 SHALL freeze state, counter and datapath, and outputs SHALL keep their current values.
REQ-022 annul=1 SHALL move any state to IDLE on the next edge, regardless of en; annul has priority over start.
REQ-023 start asserted in PREP, ITER or FIX SHALL be ignored.
REQ-024 b=0 SHALL give quotient 0xFFFFFFFF and remainder a; no exception.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-026 result SHALL remain registered with no combinational path from inputs.

Reset
REQ-027 rst=0 SHALL force IDLE, result=0, ready=0, claim=0 and counter=0, asynchronously.
REQ-028 Reset mid-operation SHALL discard the operation; after release, the unit SHALL wait for a fresh start.

Configuration
REQ-029 Macro NRDIV_EARLY_OUT_EN: when defined, PREP SHALL go directly to FIX if b=0 or |a|<|b|, skipping ITER, with quotient=0 (0xFFFFFFFF for b=0) and remainder=a; ready then rises 3 cycles after start.
REQ-030 Without NRDIV_EARLY_OUT_EN, every operation SHALL take the full 35 cycles.

Structure
REQ-031 The FSM state enum, WIDTH and the MDU control codes SHALL live in the shared package mdu_pkg.
REQ-032 One sub-module, nrdiv_step (single combinational add/sub iteration), MAY be instantiated; there SHALL be no other sub-modules.

Verification
REQ-033 Unsigned 100/7, en=1 -> at cycle 35, ready=1 and result={0x00000002,0x0000000E}; claim=1 at cycle 34 only.
REQ-034 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-035 Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}; unsigned 5/0 -> {0x00000005,0xFFFFFFFF}.
REQ-036 en=0 for 10 cycles mid-ITER -> ready at cycle 45 with the correct result; annul in ITER -> IDLE next cycle, ready stays 0.
REQ-037 rst=0 pulse at cycle 20 -> outputs 0 immediately; a new start then completes normally in 35 cycles.
REQ-038 With NRDIV_EARLY_OUT_EN, unsigned 3/10 -> ready at cycle 3 with result {0x00000003,0x00000000}.
